jtcps1_vdma: RTL and testbench
==============================

Name: jtcps1_vdma

Overview:
- Bus-master DMA engine. It is the requesting side of the main-CPU bus-sharing handshake (busreq/busack).
- Once per frame, at the start of vertical blank, it takes the 68000 bus and copies two VRAM tables into local video buffers: the object table, then the palette.
- VRAM reads go through the same SDRAM request/ok handshake the CPU uses.
- It sits between the CPU bus arbiter, the SDRAM VRAM port and the object/palette buffer RAMs.

Parameters:
- AW, 17: VRAM word-address width.
- OBJ_WORDS, 1024: words copied for the object table.
- PAL_WORDS, 3072: words copied for the palette.
- BURST, 64: maximum words moved per bus tenure before the bus is handed back.
- GAP, 16: clk cycles the bus is left to the CPU between tenures.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- LVBL  in  1  vertical blank, active low; its falling edge starts a frame transfer
- obj_base  in  AW  object table VRAM word address, sampled at start
- pal_base  in  AW  palette VRAM word address, sampled at start
- pal_update  in  1  one-cycle strobe: palette changed (used only with the optional feature)
- busreq  out  1  bus request to the CPU arbiter
- busack  in  1  bus granted
- vram_cs  out  1  VRAM read request
- vram_addr  out  AW  VRAM word address
- vram_data  in  16  read data, valid while vram_ok=1
- vram_ok  in  1  read complete
- buf_we  out  1  buffer write strobe
- buf_sel  out  1  0 = object buffer, 1 = palette buffer
- buf_addr  out  12  buffer word address
- buf_data  out  16  buffer write data
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse when the frame transfer finishes
- overrun  out  1  sticky: a start arrived while busy; cleared by the next clean start

Behaviour:
- Reset: async and immediate, from any state. All outputs are 0, state is IDLE, counters and latched bases are 0. busreq drops immediately even mid-tenure. There is no partial-frame resume.
- States and transitions:
  - IDLE → LATCH on an LVBL falling edge (registered edge detect, 1 cycle).
  - LATCH: sample obj_base/pal_base, set tbl=0, idx=0, busy=1 → REQ.
  - REQ: busreq=1 → WAIT_ACK.
  - WAIT_ACK: hold busreq; when busack=1 → RD. There is no timeout.
  - RD: vram_cs=1, vram_addr=(tbl?pal_base:obj_base)+idx modulo 2^AW → WAIT_OK.
  - WAIT_OK:
    - vram_cs and vram_addr are held stable until vram_ok=1.
    - On the vram_ok cycle: capture vram_data and drop vram_cs on the next edge.
    - The next cycle: buf_we=1 for exactly 1 cycle with buf_sel=tbl, buf_addr=idx, buf_data=captured word.
    - Then idx+1 and burst count+1.
  - After each word:
    - If idx reached the table length: go to NEXT_TBL.
    - Else if BURST words were moved this tenure: go to RELEASE.
    - Else go to RD. At least 1 idle cycle between vram_cs deassert and reassert.
  - RELEASE: busreq=0; wait busack=0; then wait GAP cycles → REQ.
  - NEXT_TBL: if tbl=0, set tbl=1 and idx=0 and continue in the same tenure, subject to the burst count. If tbl=1, go to FINISH.
  - FINISH: busreq=0; wait busack=0; done=1 for 1 cycle, busy=0 → IDLE.
- vram_ok seen in any state other than WAIT_OK is ignored.
- busack dropping while in RD/WAIT_OK: the current read completes. No new RD is issued until busack returns (WAIT_ACK with busreq still high).
- LVBL falling edge while busy: ignored, overrun=1. overrun clears on the next edge accepted in IDLE.
- Bases are frozen for the whole frame; changes mid-transfer have no effect.
- buf_addr is idx truncated to 12 bits; idx counters are 12 bits wide.
- Throughput: minimum 4 cycles per word with vram_ok returned 1 cycle after vram_cs.

Optional Feature:
- Macro: JTCPS1_VDMA_PALSKIP_EN.
- Defined:
  - A sticky pal_pending flag is set by pal_update; reset value is 1.
  - At NEXT_TBL the palette table is copied only if pal_pending=1.
  - pal_pending clears when the palette copy starts.
  - If the palette is skipped, go directly to FINISH.
- Undefined: pal_update is ignored and the palette is copied every frame.

Test Plan:
- Reset, then an LVBL fall with busack tied to busreq, delayed 1 cycle; OBJ_WORDS=4, PAL_WORDS=4, BURST=64, obj_base=0x100, pal_base=0x200, vram_ok 1 cycle after vram_cs → reads 0x100–0x103 then 0x200–0x203 in one tenure. 8 buf_we pulses with sel/addr 0/0..3 then 1/0..3. done once, busy low after.
- BURST=3, OBJ_WORDS=4 → busreq drops after 3 words and waits for busack low plus GAP=16 cycles. It re-requests, and the 4th word goes to buf_addr 3.
- vram_ok delayed 10 cycles → vram_cs and vram_addr stable throughout; exactly one buf_we carrying the data present at vram_ok.
- obj_base=0x1FFFE, AW=17, OBJ_WORDS=4 → addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Second LVBL fall while busy → overrun=1 and the transfer is unaffected. Next clean start clears overrun.
- rst asserted in WAIT_OK → busreq, vram_cs and busy go 0 asynchronously. With PALSKIP_EN and no pal_update, the second frame copies only the object table.

Source files
------------

// File: rtl/jtcps1_vdma.sv
// ---------------------------------------------------------------------------
// jtcps1_vdma : per-frame bus-master DMA copying the object table then the
// palette from VRAM into local buffers. Option: JTCPS1_VDMA_PALSKIP_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jtcps1_vdma #(
  parameter int AW        = 17,
  parameter int OBJ_WORDS = 1024,
  parameter int PAL_WORDS = 3072,
  parameter int BURST     = 64,
  parameter int GAP       = 16   // must be at least 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          LVBL,
  input  logic [AW-1:0] obj_base,
  input  logic [AW-1:0] pal_base,
  input  logic          pal_update,
  output logic          busreq,
  input  logic          busack,
  output logic          vram_cs,
  output logic [AW-1:0] vram_addr,
  input  logic [15:0]   vram_data,
  input  logic          vram_ok,
  output logic          buf_we,
  output logic          buf_sel,
  output logic [11:0]   buf_addr,
  output logic [15:0]   buf_data,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_REQ, S_WAIT_ACK, S_RD, S_WAIT_OK,
    S_STEP, S_NEXT_TBL, S_RELEASE, S_GAP, S_FINISH
  } state_t;

  localparam int BW = $clog2(BURST + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [12:0]   OBJ_LEN   = 13'(OBJ_WORDS);
  localparam logic [12:0]   PAL_LEN   = 13'(PAL_WORDS);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

  state_t        state_q, state_d;
  logic          lvbl_q, lvbl_d;
  logic [AW-1:0] obj_base_q, obj_base_d, pal_base_q, pal_base_d;
  logic          tbl_q, tbl_d;
  logic [11:0]   idx_q, idx_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          last_q, last_d;
  logic          busreq_q, busreq_d;
  logic          vram_cs_q, vram_cs_d;
  logic [AW-1:0] vram_addr_q, vram_addr_d;
  logic          buf_we_q, buf_we_d, buf_sel_q, buf_sel_d;
  logic [11:0]   buf_addr_q, buf_addr_d;
  logic [15:0]   buf_data_q, buf_data_d;
  logic          busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
  logic          pal_pending_q, pal_pending_d;

  logic          w_fall, w_pal_go, w_burst_full;
  logic [AW-1:0] w_base;
  logic [12:0]   w_len, w_idx_inc;

`ifdef JTCPS1_VDMA_PALSKIP_EN
  assign w_pal_go = pal_pending_q;
`else
  logic unused_pal_update;
  assign unused_pal_update = pal_update;
  assign w_pal_go          = 1'b1;
`endif

  assign w_fall       = lvbl_q & ~LVBL;
  assign w_base       = tbl_q ? pal_base_q : obj_base_q;
  assign w_len        = tbl_q ? PAL_LEN : OBJ_LEN;
  assign w_idx_inc    = {1'b0, idx_q} + 13'd1;
  assign w_burst_full = (burst_q == BURST_MAX);

  always_comb begin
    state_d       = state_q;
    lvbl_d        = LVBL;
    obj_base_d    = obj_base_q;
    pal_base_d    = pal_base_q;
    tbl_d         = tbl_q;
    idx_d         = idx_q;
    burst_d       = burst_q;
    gap_d         = gap_q;
    last_d        = last_q;
    busreq_d      = busreq_q;
    vram_cs_d     = vram_cs_q;
    vram_addr_d   = vram_addr_q;
    buf_we_d      = 1'b0;
    buf_sel_d     = buf_sel_q;
    buf_addr_d    = buf_addr_q;
    buf_data_d    = buf_data_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    overrun_d     = overrun_q;
    pal_pending_d = pal_pending_q;

    if (w_fall && state_q != S_IDLE) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: if (w_fall) begin
        overrun_d = 1'b0;
        state_d   = S_LATCH;
      end
      S_LATCH: begin
        obj_base_d = obj_base;
        pal_base_d = pal_base;
        tbl_d      = 1'b0;
        idx_d      = 12'd0;
        busy_d     = 1'b1;
        state_d    = S_REQ;
      end
      S_REQ: begin
        busreq_d = 1'b1;
        burst_d  = '0;
        state_d  = S_WAIT_ACK;
      end
      S_WAIT_ACK: if (busack) state_d = S_RD;
      S_RD: begin
        vram_cs_d   = 1'b1;
        vram_addr_d = w_base + AW'(idx_q);
        state_d     = S_WAIT_OK;
      end
      S_WAIT_OK: if (vram_ok) begin
        vram_cs_d  = 1'b0;
        buf_we_d   = 1'b1;
        buf_sel_d  = tbl_q;
        buf_addr_d = idx_q;
        buf_data_d = vram_data;
        idx_d      = w_idx_inc[11:0];
        burst_d    = burst_q + BW'(1);
        last_d     = (w_idx_inc == w_len);
        state_d    = S_STEP;
      end
      S_STEP: begin
        if (last_q) begin
          state_d = S_NEXT_TBL;
        end else if (w_burst_full) begin
          busreq_d = 1'b0;
          state_d  = S_RELEASE;
        end else begin
          state_d = busack ? S_RD : S_WAIT_ACK;
        end
      end
      S_NEXT_TBL: begin
        if (tbl_q || !w_pal_go) begin
          busreq_d = 1'b0;
          state_d  = S_FINISH;
        end else begin
          // The palette continues in the current tenure if budget remains.
          tbl_d         = 1'b1;
          idx_d         = 12'd0;
          pal_pending_d = 1'b0;
          if (w_burst_full) begin
            busreq_d = 1'b0;
            state_d  = S_RELEASE;
          end else begin
            state_d = busack ? S_RD : S_WAIT_ACK;
          end
        end
      end
      S_RELEASE: if (!busack) begin
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_REQ;
        else                   gap_d   = gap_q + GW'(1);
      end
      S_FINISH: if (!busack) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef JTCPS1_VDMA_PALSKIP_EN
    if (pal_update) pal_pending_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lvbl_q        <= 1'b0;
      obj_base_q    <= '0;
      pal_base_q    <= '0;
      tbl_q         <= 1'b0;
      idx_q         <= 12'd0;
      burst_q       <= '0;
      gap_q         <= '0;
      last_q        <= 1'b0;
      busreq_q      <= 1'b0;
      vram_cs_q     <= 1'b0;
      vram_addr_q   <= '0;
      buf_we_q      <= 1'b0;
      buf_sel_q     <= 1'b0;
      buf_addr_q    <= 12'd0;
      buf_data_q    <= 16'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      pal_pending_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      lvbl_q        <= lvbl_d;
      obj_base_q    <= obj_base_d;
      pal_base_q    <= pal_base_d;
      tbl_q         <= tbl_d;
      idx_q         <= idx_d;
      burst_q       <= burst_d;
      gap_q         <= gap_d;
      last_q        <= last_d;
      busreq_q      <= busreq_d;
      vram_cs_q     <= vram_cs_d;
      vram_addr_q   <= vram_addr_d;
      buf_we_q      <= buf_we_d;
      buf_sel_q     <= buf_sel_d;
      buf_addr_q    <= buf_addr_d;
      buf_data_q    <= buf_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      pal_pending_q <= pal_pending_d;
    end
  end

  assign busreq    = busreq_q;
  assign vram_cs   = vram_cs_q;
  assign vram_addr = vram_addr_q;
  assign buf_we    = buf_we_q;
  assign buf_sel   = buf_sel_q;
  assign buf_addr  = buf_addr_q;
  assign buf_data  = buf_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_jtcps1_vdma.sv
// ---------------------------------------------------------------------------
// tb_jtcps1_vdma : scoreboard bench for jtcps1_vdma with VRAM/arbiter models.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_jtcps1_vdma;

  localparam int AW = 17;
  localparam int OW = 4;
  localparam int PW = 4;
  localparam int BU = 3;
  localparam int GP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          LVBL;
  logic [AW-1:0] obj_base, pal_base;
  logic          pal_update;
  logic          busreq, busack;
  logic          vram_cs, vram_ok;
  logic [AW-1:0] vram_addr;
  logic [15:0]   vram_data;
  logic          buf_we, buf_sel;
  logic [11:0]   buf_addr;
  logic [15:0]   buf_data;
  logic          busy, done, overrun;

  jtcps1_vdma #(.AW(AW), .OBJ_WORDS(OW), .PAL_WORDS(PW), .BURST(BU), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .LVBL(LVBL), .obj_base(obj_base), .pal_base(pal_base),
    .pal_update(pal_update), .busreq(busreq), .busack(busack), .vram_cs(vram_cs),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_ok(vram_ok), .buf_we(buf_we),
    .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_data(buf_data), .busy(busy),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sel;
    logic [11:0]   addr;
    logic [AW-1:0] va;
  } wr_t;

  logic [AW-1:0] addr_q[$];
  wr_t           wr_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            done_cnt = 0;
  int            frames = 0;
  int            lat_mode = 0;   // 0: ok one cycle after cs, 1: random 1..4, 2: 10 cycles
  bit            drop_mode = 0;
  bit            spur_mode = 0;
  bit            tb_pal_pending = 1;

  function automatic logic [15:0] mem_fn(input logic [AW-1:0] a);
    logic [31:0] t;
    t = {15'd0, a} * 32'h9E3779B1;
    return t[31:16] ^ {a[16], 15'h0};
  endfunction

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the object table then (maybe) the palette, word by word.
  task automatic push_frame(input logic [AW-1:0] ob, input logic [AW-1:0] pb);
    bit copy_pal;
    for (int i = 0; i < OW; i++) begin
      addr_q.push_back(AW'(ob + i));
      wr_q.push_back('{1'b0, 12'(i), AW'(ob + i)});
    end
`ifdef JTCPS1_VDMA_PALSKIP_EN
    copy_pal = tb_pal_pending;
    tb_pal_pending = 0;
`else
    copy_pal = 1;
`endif
    if (copy_pal) begin
      for (int i = 0; i < PW; i++) begin
        addr_q.push_back(AW'(pb + i));
        wr_q.push_back('{1'b1, 12'(i), AW'(pb + i)});
      end
    end
  endtask

  // Bus arbiter: grants one cycle after the request, optionally steals the bus briefly.
  initial begin
    int  drop;
    logic breq_d;
    busack = 1'b0; breq_d = 1'b0; drop = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        busack = 1'b0; breq_d = 1'b0; drop = 0;
      end else begin
        if (drop > 0) drop--;
        else if (drop_mode && busreq && busack && $urandom_range(0, 15) == 0) drop = 3;
        busack = breq_d && (drop == 0);
        breq_d = busreq;
      end
    end
  end

  // VRAM: data is valid only on the vram_ok cycle; spurious oks while idle.
  initial begin
    int lat;
    vram_ok = 1'b0; vram_data = 16'd0; lat = -1;
    forever begin
      @(posedge clk); #1;
      vram_ok   = 1'b0;
      vram_data = 16'($urandom);
      if (rst) begin
        lat = -1;
      end else if (vram_cs) begin
        if (lat < 0) begin
          lat = (lat_mode == 0) ? 1 : (lat_mode == 2) ? 10 : int'($urandom_range(1, 4));
        end else begin
          lat--;
          if (lat == 0) begin
            vram_ok   = 1'b1;
            vram_data = mem_fn(vram_addr);
            lat       = -1;
          end
        end
      end else begin
        lat = -1;
        if (spur_mode && $urandom_range(0, 7) == 0) vram_ok = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a read or a buffer write.
  initial begin
    logic          cs_prev, ack_h1, ack_h2, breq_prev, ack_prev;
    logic [AW-1:0] cur_addr, ea;
    wr_t           ew;
    int            cyc, ack_fall_cyc, ten_words;
    bit            first_req;
    cs_prev = 0; ack_h1 = 0; ack_h2 = 0; breq_prev = 0; ack_prev = 0;
    cur_addr = '0; cyc = 0; ack_fall_cyc = 0; ten_words = 0; first_req = 1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        cs_prev = 0; ack_h1 = 0; ack_h2 = 0; breq_prev = 0; ack_prev = 0;
        ten_words = 0; first_req = 1;
      end else begin
        if (vram_cs && !cs_prev) begin
          chk(ack_h2 == 1'b1, "read_without_grant", ack_h2, 1);
          if (addr_q.size() == 0) begin
            chk(1'b0, "unexpected_read", vram_addr, 0);
          end else begin
            ea = addr_q.pop_front();
            chk(vram_addr == ea, "read_addr", vram_addr, ea);
          end
          cur_addr = vram_addr;
        end else if (vram_cs) begin
          chk(vram_addr == cur_addr, "addr_stable", vram_addr, cur_addr);
        end
        if (vram_cs && vram_ok) begin
          ten_words++;
          chk(ten_words <= BU, "burst_len", ten_words, BU);
        end
        if (busreq && !breq_prev) begin
          if (!first_req) chk(cyc - ack_fall_cyc >= GP, "bus_gap", cyc - ack_fall_cyc, GP);
          first_req = 0;
          ten_words = 0;
        end
        if (!busack && ack_prev) ack_fall_cyc = cyc;
        if (buf_we) begin
          chk(busy == 1'b1, "busy_on_write", busy, 1);
          if (wr_q.size() == 0) begin
            chk(1'b0, "unexpected_write", buf_addr, 0);
          end else begin
            ew = wr_q.pop_front();
            chk(buf_sel == ew.sel, "buf_sel", buf_sel, ew.sel);
            chk(buf_addr == ew.addr, "buf_addr", buf_addr, ew.addr);
            chk(buf_data == mem_fn(ew.va), "buf_data", buf_data, mem_fn(ew.va));
          end
        end
        if (done) begin
          chk(busy == 1'b0, "busy_at_done", busy, 0);
          chk(wr_q.size() == 0, "writes_left_at_done", wr_q.size(), 0);
          done_cnt++;
          first_req = 1;
        end
        cs_prev = vram_cs; ack_h2 = ack_h1; ack_h1 = busack;
        breq_prev = busreq; ack_prev = busack;
      end
    end
  end

  task automatic start_frame();
    @(negedge clk);
    push_frame(obj_base, pal_base);
    LVBL = 1'b0;
    repeat (3) @(negedge clk);
    LVBL = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(done_cnt >= target, "done_timeout", done_cnt, target);
    repeat (3) @(negedge clk);
    chk(done_cnt == target, "done_once", done_cnt, target);
    chk(busy == 1'b0, "busy_after_done", busy, 0);
    chk(busreq == 1'b0, "busreq_after_done", busreq, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; LVBL = 1'b1; obj_base = '0; pal_base = '0; pal_update = 1'b0;
    repeat (3) @(negedge clk);
    chk(busreq == 0, "rst_busreq", busreq, 0);
    chk(vram_cs == 0, "rst_vram_cs", vram_cs, 0);
    chk(vram_addr == 0, "rst_vram_addr", vram_addr, 0);
    chk(buf_we == 0, "rst_buf_we", buf_we, 0);
    chk(buf_sel == 0, "rst_buf_sel", buf_sel, 0);
    chk(buf_addr == 0, "rst_buf_addr", buf_addr, 0);
    chk(buf_data == 0, "rst_buf_data", buf_data, 0);
    chk(busy == 0, "rst_busy", busy, 0);
    chk(done == 0, "rst_done", done, 0);
    chk(overrun == 0, "rst_overrun", overrun, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic frame, then address wrap at the top of VRAM, then slow VRAM.
    obj_base = 17'h00100; pal_base = 17'h00200;
    start_frame(); frames++; wait_done(frames);
    obj_base = 17'h1FFFE; pal_base = 17'h1FFFF;
    start_frame(); frames++; wait_done(frames);
    lat_mode = 2; obj_base = 17'h0ABCD; pal_base = 17'h12340;
    start_frame(); frames++; wait_done(frames);
    lat_mode = 0;

    // A second LVBL fall while busy only flags overrun.
    obj_base = 17'h00400; pal_base = 17'h00800;
    start_frame(); frames++;
    repeat (8) @(negedge clk);
    LVBL = 1'b0;
    repeat (2) @(negedge clk);
    LVBL = 1'b1;
    repeat (3) @(negedge clk);
    chk(overrun == 1'b1, "overrun_set", overrun, 1);
    wait_done(frames);
    chk(overrun == 1'b1, "overrun_sticky", overrun, 1);
    start_frame(); frames++;
    repeat (2) @(negedge clk);
    chk(overrun == 1'b0, "overrun_clear", overrun, 0);
    wait_done(frames);

    for (int f = 0; f < 10; f++) begin
      lat_mode  = int'($urandom_range(0, 2));
      drop_mode = 1'($urandom_range(0, 1));
      spur_mode = 1'($urandom_range(0, 1));
      obj_base  = AW'($urandom);
      pal_base  = AW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk); pal_update = 1'b1;
        @(negedge clk); pal_update = 1'b0;
        tb_pal_pending = 1;
      end
      repeat ($urandom_range(1, 20)) @(negedge clk);
      start_frame(); frames++;
      obj_base = AW'($urandom);
      pal_base = AW'($urandom);
      wait_done(frames);
    end

    // Asynchronous reset while a read is outstanding.
    lat_mode = 2; drop_mode = 0; spur_mode = 0;
    obj_base = 17'h03000; pal_base = 17'h04000;
    start_frame();
    n = 0;
    while (!vram_cs && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(vram_cs == 1'b1, "reach_wait_ok", vram_cs, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk(busreq == 0, "async_rst_busreq", busreq, 0);
    chk(vram_cs == 0, "async_rst_vram_cs", vram_cs, 0);
    chk(busy == 0, "async_rst_busy", busy, 0);
    addr_q.delete();
    wr_q.delete();
    tb_pal_pending = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lat_mode = 0;
    repeat (2) @(negedge clk);

    obj_base = 17'h05000; pal_base = 17'h06000;
    start_frame(); frames++; wait_done(frames);
    obj_base = 17'h07000; pal_base = 17'h08000;
    start_frame(); frames++; wait_done(frames);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
